ssd_scan: RTL and testbench
===========================

SSD_SCAN -- requirements
Module: ssd_scan

Interface
REQ-001 Parameter NUM_DIGITS, default 8, number of multiplexed digits (1..16).
REQ-002 Parameter REFRESH_DIV, default 100000, clock cycles per digit slot (>=4).
REQ-003 Parameter BRIGHT_W, default 4, brightness control width.
REQ-004 clk_in  input  1  system clock; all logic on its rising edge.
REQ-005 rst_in  input  1  asynchronous, active-low reset.
REQ-006 val_in  input  4*NUM_DIGITS  hex nibbles; nibble i drives digit i, digit 0 rightmost.
REQ-007 blank_in  input  NUM_DIGITS  per-digit force-blank mask.
REQ-008 lzb_en_in  input  1  leading-zero blanking enable.
REQ-009 bright_in  input  BRIGHT_W  brightness level.
REQ-010 cat_out  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-011 an_out  output  NUM_DIGITS  active-low anodes, one-hot-low or all high.
REQ-012 frame_out  output  1  one-cycle pulse at each frame start.

Function
REQ-013 Prescaler shall count 0..REFRESH_DIV-1 and wrap; at terminal count the digit index shall advance, wrapping NUM_DIGITS-1 -> 0.
REQ-014 On the cycle the index wraps to 0 (and the first cycle after reset release), all inputs shall be latched into shadow registers and frame_out shall pulse high for that cycle.
REQ-015 Mid-frame input changes shall not affect outputs until the next latch.
REQ-016 Duty threshold shall be latched as thr = ((bright_in+1)*REFRESH_DIV) >> BRIGHT_W, computed at full width without overflow.
REQ-017 Current digit anode shall be low while prescaler < thr, high otherwise; max brightness gives 100% duty.
REQ-018 At latch time, leading-zero mask shall mark digits from NUM_DIGITS-1 downward while nibble == 0, stopping at first nonzero; digit 0 shall never be LZB-blanked.
REQ-019 A digit blanked by blank_in or LZB shall drive an_out all high and cat_out 7'h7F for its whole slot.
REQ-020 cat_out and an_out shall be registered, one cycle after prescaler/index state; anode and cathode shall change in the same cycle.
REQ-021 Hex font: standard 0-9, A, b, C, d, E, F glyphs.

Reset
REQ-022 While rst_in low: prescaler 0, index 0, shadow registers 0, an_out all ones, cat_out 7'h7F, frame_out 0, dp_out 1; assertion mid-frame shall take effect without a clock.
REQ-023 First rising edge after release shall latch inputs and pulse frame_out; digit 0 shall display on the following cycle.

Configuration
REQ-024 Macro SSD_SCAN_DP_EN defined: ports dp_in (input, NUM_DIGITS, per-digit decimal point) and dp_out (output, 1, active-low) shall exist; dp_in latched with the other inputs; dp_out gated with the anode and forced high for blanked digits.
REQ-025 Macro undefined: neither port exists; no decimal-point logic.

Structure
REQ-026 Package ssd_pkg shall hold the segment-pattern type, blank constant 7'h7F and the hex font table.
REQ-027 Sub-module ssd_hex_font shall map 4-bit nibble to 7-bit active-low pattern (combinational).

Verification (NUM_DIGITS=8, REFRESH_DIV=4, BRIGHT_W=2 unless noted)
REQ-028 val_in=32'h0123_ABCD, bright_in=3 -> an_out FE,FD,FB,...,7F, 4 cycles each; digit 0 cat_out=7'b0100001; frame_out every 32 cycles.
REQ-029 val_in=32'h0000_00A0, lzb_en_in=1 -> only FE (cat 7'b1000000) and FD (cat 7'b0001000) ever low; other slots an_out=8'hFF.
REQ-030 val_in=0, lzb_en_in=1 -> only digit 0 lit showing 7'b1000000.
REQ-031 bright_in=0 -> thr=1; each anode low 1 of every 4 cycles.
REQ-032 change val_in at cycle 10 of a frame -> outputs unchanged until next frame_out pulse.
REQ-033 drop rst_in mid-slot -> an_out=8'hFF and cat_out=7'h7F immediately, without clock edge; release -> frame_out pulse on first edge.

Source files
------------

// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared segment type, blank pattern and hex font table
package ssd_pkg;

   // Active-low segment pattern, bit order {g,f,e,d,c,b,a}.
   typedef logic [6:0] seg_t;

   // All segments off.
   localparam seg_t SEG_BLANK = 7'h7F;

   // Active-low hex glyphs, entry 15 first: F E d C b A 9 8 7 6 5 4 3 2 1 0.
   localparam logic [15:0][6:0] HEX_FONT = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

endpackage

// File: rtl/ssd_hex_font.sv
// rtl/ssd_hex_font.sv - combinational nibble to active-low seven-segment glyph
module ssd_hex_font
   import ssd_pkg::*;
(
   input  logic [3:0] nibble,
   output seg_t       seg
);

   assign seg = HEX_FONT[nibble];

endmodule

// File: rtl/ssd_scan.sv
// rtl/ssd_scan.sv - multiplexed seven-segment scanner with PWM dimming and leading-zero blanking; optional decimal points under SSD_SCAN_DP_EN
module ssd_scan
   import ssd_pkg::*;
#(
   parameter int NUM_DIGITS  = 8,
   parameter int REFRESH_DIV = 100000,
   parameter int BRIGHT_W    = 4
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic [4*NUM_DIGITS-1:0] val_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   input  logic                    lzb_en_in,
   input  logic [BRIGHT_W-1:0]     bright_in,
`ifdef SSD_SCAN_DP_EN
   input  logic [NUM_DIGITS-1:0]   dp_in,
   output logic                    dp_out,
`endif
   output logic [6:0]              cat_out,
   output logic [NUM_DIGITS-1:0]   an_out,
   output logic                    frame_out
);

   // Prescaler is wide enough to also hold the threshold value REFRESH_DIV.
   localparam int CNT_W  = $clog2(REFRESH_DIV + 1);
   localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   // (bright+1) <= 2**BRIGHT_W and REFRESH_DIV < 2**CNT_W, so this never overflows.
   localparam int PROD_W = CNT_W + BRIGHT_W + 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   // Scan state.
   logic [CNT_W-1:0] presc;
   logic [IDX_W-1:0] idx;
   logic             started;
   logic             latch;

   // Frame shadow copies of the inputs.
   logic [NUM_DIGITS-1:0][3:0] val_sh;
   logic [NUM_DIGITS-1:0]      blank_sh;
   logic [CNT_W-1:0]           thr_sh;
`ifdef SSD_SCAN_DP_EN
   logic [NUM_DIGITS-1:0]      dp_sh;
`endif

   // Values captured at the next latch.
   logic [NUM_DIGITS-1:0][3:0] val_nib;
   logic [NUM_DIGITS-1:0]      lzb_mask;
   logic                       lzb_run;
   logic [PROD_W-1:0]          thr_prod;
   logic [CNT_W-1:0]           thr_next;

   // Current-slot decode.
   logic                  digit_on;
   logic                  cur_blank;
   seg_t                  font_seg;
   logic [NUM_DIGITS-1:0] an_next;
   seg_t                  cat_next;
`ifdef SSD_SCAN_DP_EN
   logic                  dp_next;
`endif

   assign val_nib = val_in;

   // The first edge after reset and the last slot of a frame both start a new frame.
   assign latch = !started || ((presc == CNT_LAST) && (idx == IDX_LAST));

   assign thr_prod = (PROD_W'(bright_in) + PROD_W'(1)) * PROD_W'(REFRESH_DIV);
   assign thr_next = CNT_W'(thr_prod >> BRIGHT_W);

   // Leading-zero run from the top digit down; digit 0 is never part of it.
   always_comb begin
      lzb_mask = '0;
      lzb_run  = lzb_en_in;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         if (val_nib[i] != 4'h0) begin
            lzb_run = 1'b0;
         end
         lzb_mask[i] = lzb_run;
      end
   end

   // Prescaler and digit index; a frame latch restarts both at slot 0.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         presc     <= '0;
         idx       <= '0;
         started   <= 1'b0;
         frame_out <= 1'b0;
      end else begin
         started   <= 1'b1;
         frame_out <= latch;
         if (latch) begin
            presc <= '0;
            idx   <= '0;
         end else if (presc == CNT_LAST) begin
            presc <= '0;
            idx   <= idx + IDX_W'(1);
         end else begin
            presc <= presc + CNT_W'(1);
         end
      end
   end

   // Shadow registers hold the inputs steady for a whole frame.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         val_sh   <= '0;
         blank_sh <= '0;
         thr_sh   <= '0;
`ifdef SSD_SCAN_DP_EN
         dp_sh    <= '0;
`endif
      end else if (latch) begin
         val_sh   <= val_nib;
         blank_sh <= blank_in | lzb_mask;
         thr_sh   <= thr_next;
`ifdef SSD_SCAN_DP_EN
         dp_sh    <= dp_in;
`endif
      end
   end

   ssd_hex_font u_font (
      .nibble (val_sh[idx]),
      .seg    (font_seg)
   );

   assign cur_blank = !started || blank_sh[idx];
   assign digit_on  = !cur_blank && (presc < thr_sh);

   // Decode the next anode and cathode values for the current slot.
   always_comb begin
      an_next = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (digit_on && (idx == IDX_W'(i))) begin
            an_next[i] = 1'b0;
         end
      end
      cat_next = cur_blank ? SEG_BLANK : font_seg;
   end

`ifdef SSD_SCAN_DP_EN
   assign dp_next = !(digit_on && dp_sh[idx]);
`endif

   // Registered drivers so anode and cathode switch on the same edge.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         an_out  <= '1;
         cat_out <= SEG_BLANK;
`ifdef SSD_SCAN_DP_EN
         dp_out  <= 1'b1;
`endif
      end else begin
         an_out  <= an_next;
         cat_out <= cat_next;
`ifdef SSD_SCAN_DP_EN
         dp_out  <= dp_next;
`endif
      end
   end

endmodule

// File: tb/tb_ssd_scan.sv
// tb/tb_ssd_scan.sv - directed self-checking bench for ssd_scan (8 digits, 4-cycle slots, 2-bit brightness)
module tb_ssd_scan;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] val   = '0;
   logic [7:0]  blank = '0;
   logic        lzb_en = 1'b0;
   logic [1:0]  bright = '0;
   logic [6:0]  cat;
   logic [7:0]  an;
   logic        frame;
`ifdef SSD_SCAN_DP_EN
   logic [7:0]  dp = '0;
   logic        dp_o;
`endif

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0] e_an [8];
   logic [6:0] e_cat [8];
   int         e_thr;

   always #5 clk = ~clk;

   ssd_scan #(
      .NUM_DIGITS  (8),
      .REFRESH_DIV (4),
      .BRIGHT_W    (2)
   ) dut (
      .clk_in    (clk),
      .rst_in    (rst_n),
      .val_in    (val),
      .blank_in  (blank),
      .lzb_en_in (lzb_en),
      .bright_in (bright),
`ifdef SSD_SCAN_DP_EN
      .dp_in     (dp),
      .dp_out    (dp_o),
`endif
      .cat_out   (cat),
      .an_out    (an),
      .frame_out (frame)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic apply(input logic [31:0] v, input logic [7:0] b, input logic l, input logic [1:0] br);
      val    = v;
      blank  = b;
      lzb_en = l;
      bright = br;
   endtask

   task automatic apply_stage(input int id);
      case (id)
         2: apply(32'h0000_00A0, 8'h00, 1'b1, 2'd3);
         3: apply(32'h0000_0000, 8'h00, 1'b1, 2'd3);
         4: apply(32'h0123_ABCD, 8'h04, 1'b0, 2'd0);
         default: apply(32'h0123_ABCD, 8'h00, 1'b0, 2'd3);
      endcase
   endtask

   task automatic wait_frame();
      int n = 0;
      while (frame !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("frame_found", {7'b0, frame}, 8'h01);
   endtask

   // One full frame of 32 cycles; the next stage's inputs change mid-frame at k==10.
   task automatic run_frame(input string name, input int hook);
      logic [7:0] exp_an;
      int d;
      int p;
      for (int k = 0; k < 32; k++) begin
         @(negedge clk);
         d = k / 4;
         p = k % 4;
         exp_an = (p < e_thr) ? e_an[d] : 8'hFF;
         check($sformatf("%s_an[%0d]", name, k), an, exp_an);
         if (exp_an != 8'hFF || e_an[d] == 8'hFF)
            check($sformatf("%s_cat[%0d]", name, k), {1'b0, cat}, {1'b0, e_cat[d]});
         check($sformatf("%s_frame[%0d]", name, k), {7'b0, frame}, {7'b0, (k == 31)});
         if (k == 10) apply_stage(hook);
      end
   endtask

   initial begin
      apply(32'h0123_ABCD, 8'h00, 1'b0, 2'd3);
      rst_n = 1'b0;
      #3;
      check("rst_an", an, 8'hFF);
      check("rst_cat", {1'b0, cat}, 8'h7F);
      check("rst_frame", {7'b0, frame}, 8'h00);

      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("first_frame", {7'b0, frame}, 8'h01);
      check("first_an", an, 8'hFF);

      // Full brightness, all digits, mid-frame input change must not show.
      e_an  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
      e_cat = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h30, 7'h24, 7'h79, 7'h40};
      e_thr = 4;
      run_frame("hex", 2);

      // 0x000000A0 with leading-zero blanking: digits 1 and 0 only.
      wait_frame();
      e_an  = '{8'hFE, 8'hFD, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      e_cat = '{7'h40, 7'h08, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
      e_thr = 4;
      run_frame("lzb_a0", 3);

      // All zero with leading-zero blanking: digit 0 still shows 0.
      wait_frame();
      e_an  = '{8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      e_cat = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
      e_thr = 4;
      run_frame("lzb_zero", 4);

      // Minimum brightness (1 of 4 cycles) with digit 2 force-blanked.
      wait_frame();
      e_an  = '{8'hFE, 8'hFD, 8'hFF, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
      e_cat = '{7'h21, 7'h46, 7'h7F, 7'h08, 7'h30, 7'h24, 7'h79, 7'h40};
      e_thr = 1;
      run_frame("dim", 5);

      // Asynchronous reset in the middle of digit 1's slot.
      wait_frame();
      repeat (5) @(negedge clk);
      check("pre_rst_an", an, 8'hFD);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_an", an, 8'hFF);
      check("async_rst_cat", {1'b0, cat}, 8'h7F);
      check("async_rst_frame", {7'b0, frame}, 8'h00);
      @(negedge clk);
      @(negedge clk);
      check("held_rst_an", an, 8'hFF);
      rst_n = 1'b1;
      @(negedge clk);
      check("rel_frame", {7'b0, frame}, 8'h01);
      check("rel_an", an, 8'hFF);
      check("rel_cat", {1'b0, cat}, 8'h7F);
      @(negedge clk);
      check("rel_d0_an", an, 8'hFE);
      check("rel_d0_cat", {1'b0, cat}, 8'h21);
      check("rel_d0_frame", {7'b0, frame}, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
